// File: rtl/uart_tx_frame_if.sv
// Host-side byte handshake into the UART transmit framer.
// master = byte source (host/register block), slave = framer.
interface uart_tx_frame_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] tx_data;
   logic              tx_valid;
   logic              tx_ready;

   modport master (
      output tx_data,
      output tx_valid,
      input  tx_ready
   );

   modport slave (
      input  tx_data,
      input  tx_valid,
      output tx_ready
   );
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, DATA_W data bits LSB first, optional parity,
// 1 or 2 stop bits. Every bit edge lands on a baud_tick from the baud counter.
module uart_tx_frame #(
   parameter int DATA_W     = 8,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   uart_tx_frame_if.slave   s_if,
   input  logic             i_baud_tick,
   output logic             o_txd,
   output logic             o_busy,
   output logic             o_tx_done
);

   // Anything other than 2 stop bits collapses to 1.
   localparam int STOP_N = (STOP_BITS == 2) ? 2 : 1;
   localparam int CNT_W  = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_W - 1);
   localparam logic             LAST_STOP = (STOP_N == 2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t            r_state;
   logic [DATA_W-1:0] r_shift;
   logic              r_parity;
   logic [CNT_W-1:0]  r_bit_cnt;
   logic              r_stop_cnt;
   logic              r_txd;
   logic              r_ready;
   logic              r_busy;
   logic              r_done;

   logic              w_accept;
   logic              w_par_bit;

   assign w_accept  = s_if.tx_valid & r_ready;
   // Parity is fixed at accept time so later tx_data changes cannot leak in.
   assign w_par_bit = (^s_if.tx_data) ^ (PARITY_ODD != 0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_shift    <= '0;
         r_parity   <= 1'b0;
         r_bit_cnt  <= '0;
         r_stop_cnt <= 1'b0;
         r_txd      <= 1'b1;
         r_ready    <= 1'b1;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_txd <= 1'b1;
               // A tick coinciding with the accept is deliberately not used.
               if (w_accept) begin
                  r_shift  <= s_if.tx_data;
                  r_parity <= w_par_bit;
                  r_ready  <= 1'b0;
                  r_busy   <= 1'b1;
                  r_state  <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (i_baud_tick) begin
                  r_txd   <= 1'b0;
                  r_state <= S_START;
               end
            end
            S_START: begin
               if (i_baud_tick) begin
                  r_txd     <= r_shift[0];
                  r_shift   <= r_shift >> 1;
                  r_bit_cnt <= '0;
                  r_state   <= S_DATA;
               end
            end
            S_DATA: begin
               if (i_baud_tick) begin
                  if (r_bit_cnt == LAST_BIT) begin
                     if (PARITY_EN != 0) begin
                        r_txd   <= r_parity;
                        r_state <= S_PARITY;
                     end else begin
                        r_txd      <= 1'b1;
                        r_stop_cnt <= 1'b0;
                        r_state    <= S_STOP;
                     end
                  end else begin
                     r_txd     <= r_shift[0];
                     r_shift   <= r_shift >> 1;
                     r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                  end
               end
            end
            S_PARITY: begin
               if (i_baud_tick) begin
                  r_txd      <= 1'b1;
                  r_stop_cnt <= 1'b0;
                  r_state    <= S_STOP;
               end
            end
            S_STOP: begin
               if (i_baud_tick) begin
                  if (r_stop_cnt == LAST_STOP) begin
                     r_state <= S_IDLE;
                     r_done  <= 1'b1;
                     r_busy  <= 1'b0;
                     r_ready <= 1'b1;
                  end else begin
                     r_stop_cnt <= r_stop_cnt + 1'b1;
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_txd   <= 1'b1;
               r_busy  <= 1'b0;
               r_ready <= 1'b1;
            end
         endcase
      end
   end

   assign s_if.tx_ready = r_ready;
   assign o_txd         = r_txd;
   assign o_busy        = r_busy;
   assign o_tx_done     = r_done;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: four instances cover no-parity, even,
// odd parity and two stop bits; baud_tick pulses every 4 clocks.
module tb_uart_tx_frame;

   logic clk;
   logic rst_n;
   logic baud_tick;

   logic [3:0] valid_v;
   logic [7:0] data_v [4];

   logic [3:0] w_txd;
   logic [3:0] w_busy;
   logic [3:0] w_done;
   logic [3:0] w_ready;

   int n_vec = 0;
   int n_err = 0;

   logic c_txd   [0:511];
   logic c_busy  [0:511];
   logic c_ready [0:511];
   logic c_done  [0:511];

   uart_tx_frame_if #(.DATA_W(8)) if0 ();
   uart_tx_frame_if #(.DATA_W(8)) if1 ();
   uart_tx_frame_if #(.DATA_W(8)) if2 ();
   uart_tx_frame_if #(.DATA_W(8)) if3 ();

   assign if0.tx_valid = valid_v[0];
   assign if1.tx_valid = valid_v[1];
   assign if2.tx_valid = valid_v[2];
   assign if3.tx_valid = valid_v[3];
   assign if0.tx_data  = data_v[0];
   assign if1.tx_data  = data_v[1];
   assign if2.tx_data  = data_v[2];
   assign if3.tx_data  = data_v[3];
   assign w_ready = {if3.tx_ready, if2.tx_ready, if1.tx_ready, if0.tx_ready};

   uart_tx_frame #(.DATA_W(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut0 (
      .clk(clk), .rst_n(rst_n), .s_if(if0), .i_baud_tick(baud_tick),
      .o_txd(w_txd[0]), .o_busy(w_busy[0]), .o_tx_done(w_done[0]));
   uart_tx_frame #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .s_if(if1), .i_baud_tick(baud_tick),
      .o_txd(w_txd[1]), .o_busy(w_busy[1]), .o_tx_done(w_done[1]));
   uart_tx_frame #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut2 (
      .clk(clk), .rst_n(rst_n), .s_if(if2), .i_baud_tick(baud_tick),
      .o_txd(w_txd[2]), .o_busy(w_busy[2]), .o_tx_done(w_done[2]));
   uart_tx_frame #(.DATA_W(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut3 (
      .clk(clk), .rst_n(rst_n), .s_if(if3), .i_baud_tick(baud_tick),
      .o_txd(w_txd[3]), .o_busy(w_busy[3]), .o_tx_done(w_done[3]));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      baud_tick = 1'b0;
      forever begin
         repeat (3) @(negedge clk);
         baud_tick = 1'b1;
         @(negedge clk);
         baud_tick = 1'b0;
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout, required finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic sample(input int sel, input int k);
      @(negedge clk);
      c_txd[k]   = w_txd[sel];
      c_busy[k]  = w_busy[sel];
      c_ready[k] = w_ready[sel];
      c_done[k]  = w_done[sel];
   endtask

   // Each bit period is 4 samples starting at s; all must match the expected bit.
   task automatic check_bits(input string name, input int s, input logic [0:11] exp,
                             input int n, input int lim);
      for (int i = 0; i < n; i++) begin
         logic ok;
         ok = 1'b1;
         for (int j = 0; j < 4; j++) begin
            int idx;
            idx = s + 4 * i + j;
            if (idx >= lim || idx < 1 || c_txd[idx] !== exp[i]) ok = 1'b0;
         end
         chk($sformatf("%s_bit%0d", name, i), {31'd0, ok}, 32'd1);
      end
   endtask

   task automatic send_frame(input int sel, input logic [7:0] data, input logic [0:11] exp,
                             input int n, input bit disturb);
      int s;
      int d;
      logic busy_ok;
      s = -1;
      d = -1;
      chk("ready_before_send", {31'd0, w_ready[sel]}, 32'd1);
      data_v[sel]  = data;
      valid_v[sel] = 1'b1;
      for (int k = 1; k < 300 && d < 0; k++) begin
         sample(sel, k);
         if (k == 1) chk("accept_drops_ready", {31'd0, c_ready[1]}, 32'd0);
         if (s < 0 && c_txd[k] == 1'b0) s = k;
         if (c_done[k]) begin
            d = k;
            valid_v[sel] = 1'b0;
         end else if (disturb) begin
            valid_v[sel] = 1'($urandom);
            data_v[sel]  = 8'($urandom);
         end else begin
            valid_v[sel] = 1'b0;
         end
      end
      valid_v[sel] = 1'b0;
      chk("tx_done_seen", {31'd0, d > 0}, 32'd1);
      if (d > 0) begin
         chk("start_latency_ok", {31'd0, (s >= 2 && s <= 5)}, 32'd1);
         check_bits("frame", s, exp, n, d);
         chk("frame_length", 32'(d - s), 32'(4 * n));
         busy_ok = 1'b1;
         for (int k = 1; k < d; k++) if (c_busy[k] !== 1'b1) busy_ok = 1'b0;
         chk("busy_whole_frame", {31'd0, busy_ok}, 32'd1);
         chk("busy_low_at_done", {31'd0, c_busy[d]}, 32'd0);
         chk("ready_at_done", {31'd0, c_ready[d]}, 32'd1);
         sample(sel, d + 1);
         chk("done_single_pulse", {31'd0, c_done[d + 1]}, 32'd0);
         chk("txd_idle_after", {31'd0, c_txd[d + 1]}, 32'd1);
      end
      $display("frame dut%0d data=%02h bits=%0d start=%0d done=%0d", sel, data, n, s, d);
   endtask

   typedef struct {
      int          sel;
      logic [7:0]  data;
      logic [0:11] bits;
      int          n;
      bit          disturb;
   } vec_t;

   vec_t vt [10];

   initial begin
      int s1, d1, s2, d2;
      logic ok;

      // Expected line levels in transmission order, leftmost = start bit.
      vt[0] = '{0, 8'hA5, 12'b0_10100101_1_00, 10, 1'b0};
      vt[1] = '{0, 8'h00, 12'b0_00000000_1_00, 10, 1'b1};
      vt[2] = '{0, 8'hFF, 12'b0_11111111_1_00, 10, 1'b0};
      vt[3] = '{0, 8'h3C, 12'b0_00111100_1_00, 10, 1'b1};
      vt[4] = '{1, 8'hA5, 12'b0_10100101_0_1_0, 11, 1'b0};
      vt[5] = '{2, 8'hA5, 12'b0_10100101_1_1_0, 11, 1'b0};
      vt[6] = '{1, 8'h01, 12'b0_10000000_1_1_0, 11, 1'b0};
      vt[7] = '{2, 8'h01, 12'b0_10000000_0_1_0, 11, 1'b1};
      vt[8] = '{3, 8'h00, 12'b0_00000000_11_0, 11, 1'b0};
      vt[9] = '{3, 8'h81, 12'b0_10000001_11_0, 11, 1'b0};

      rst_n   = 1'b0;
      valid_v = 4'b0000;
      for (int i = 0; i < 4; i++) data_v[i] = 8'h00;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 4; i++)
         chk($sformatf("reset_state_dut%0d", i),
             {28'd0, w_txd[i], w_ready[i], w_busy[i], w_done[i]}, 32'b1100);
      rst_n = 1'b1;

      // Ticks while idle must leave the line high.
      ok = 1'b1;
      repeat (12) begin
         @(negedge clk);
         if (w_txd !== 4'b1111 || w_busy !== 4'b0000 || w_done !== 4'b0000) ok = 1'b0;
      end
      chk("idle_ticks_quiet", {31'd0, ok}, 32'd1);

      for (int v = 0; v < 10; v++)
         send_frame(vt[v].sel, vt[v].data, vt[v].bits, vt[v].n, vt[v].disturb);

      // Back-to-back with tx_valid held: 0x55 then 0x0F.
      s1 = -1; d1 = -1; s2 = -1; d2 = -1;
      data_v[0]  = 8'h55;
      valid_v[0] = 1'b1;
      for (int k = 1; k < 400 && d2 < 0; k++) begin
         sample(0, k);
         if (k == 1) data_v[0] = 8'h0F;
         if (s1 < 0 && c_txd[k] == 1'b0) s1 = k;
         if (d1 > 0 && k == d1 + 1) begin
            chk("b2b_second_accept", {31'd0, c_ready[k]}, 32'd0);
            valid_v[0] = 1'b0;
         end
         if (d1 > 0 && k > d1 && s2 < 0 && c_txd[k] == 1'b0) s2 = k;
         if (c_done[k]) begin
            if (d1 < 0) d1 = k;
            else d2 = k;
         end
      end
      valid_v[0] = 1'b0;
      chk("b2b_two_done", {31'd0, (d1 > 0 && d2 > 0)}, 32'd1);
      if (d1 > 0 && d2 > 0) begin
         check_bits("b2b_f1", s1, 12'b0_10101010_1_00, 10, d1);
         check_bits("b2b_f2", s2, 12'b0_11110000_1_00, 10, d2);
         chk("b2b_f1_length", 32'(d1 - s1), 32'd40);
         chk("b2b_gap_start2", 32'(s2 - d1), 32'd4);
         chk("b2b_f2_length", 32'(d2 - s2), 32'd40);
      end
      $display("b2b dut0 55/0F start1=%0d done1=%0d start2=%0d done2=%0d", s1, d1, s2, d2);

      // Reset during data bit 3 (a 0 bit of 0xA5), then a clean 0x3C frame.
      s1 = -1;
      data_v[0]  = 8'hA5;
      valid_v[0] = 1'b1;
      for (int k = 1; k < 100; k++) begin
         sample(0, k);
         valid_v[0] = 1'b0;
         if (s1 < 0 && c_txd[k] == 1'b0) s1 = k;
         if (s1 > 0 && k == s1 + 18) break;
      end
      chk("rst_bit3_low_before", {31'd0, w_txd[0]}, 32'd0);
      rst_n = 1'b0;
      #1;
      chk("rst_async_state", {29'd0, w_txd[0], w_ready[0], w_busy[0]}, 32'b110);
      ok = 1'b1;
      repeat (6) begin
         @(negedge clk);
         if (w_done !== 4'b0000 || w_txd[0] !== 1'b1) ok = 1'b0;
      end
      rst_n = 1'b1;
      repeat (2) begin
         @(negedge clk);
         if (w_done !== 4'b0000) ok = 1'b0;
      end
      chk("rst_no_done", {31'd0, ok}, 32'd1);
      $display("reset mid-frame dut0 at bit3, start=%0d", s1);
      send_frame(0, 8'h3C, 12'b0_00111100_1_00, 10, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
